// File: rtl/pow_seq_ctrl.sv
// pow_seq_ctrl: sequential exponentiation controller.
// Computes OUT = A^E mod 2^W with one shared W x W multiplier, using
// right-to-left square-and-multiply. Latency is fixed regardless of data.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request, sampled only in IDLE
//   A      - base, captured on the accepted start edge
//   E      - exponent, captured on the accepted start edge
//   OUT    - registered result A^E mod 2^W, valid from the done cycle
//   busy   - high during MUL/SQR iteration
//   done   - one-cycle completion pulse
//   ovf    - true A^E >= 2^W, valid with done
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | conditionally fold base into res (exp[0])
// SQR    | square base, shift exp, count iteration
// DONE   | OUT/ovf valid, done pulse, back to IDLE
module pow_seq_ctrl #(
    parameter int W  = 7,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  A,
    input  logic [EW-1:0] E,
    output logic [W-1:0]  OUT,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int CW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SQR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   base_q, base_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_int_q, ovf_int_d;
    logic [W-1:0]   out_q, out_d;
    logic           ovf_q, ovf_d;

    // Shared multiplier: MUL uses res*base, every other state base*base.
    logic [W-1:0]   mul_a;
    logic [2*W-1:0] prod;
    logic [W-1:0]   prod_lo;
    logic           prod_hi_nz;
    logic [EW-1:0]  exp_shr;

    assign mul_a      = (state_q == S_MUL) ? res_q : base_q;
    assign prod       = (2*W)'(mul_a) * (2*W)'(base_q);
    assign prod_lo    = prod[W-1:0];
    assign prod_hi_nz = (prod[2*W-1:W] != '0);
    assign exp_shr    = exp_q >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            res_q     <= '0;
            base_q    <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            base_q    <= base_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        base_d    = base_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        out_d     = out_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    res_d     = W'(1);
                    base_d    = A;
                    exp_d     = E;
                    cnt_d     = '0;
                    ovf_int_d = 1'b0;
                    state_d   = S_MUL;
                end
            end
            S_MUL: begin
                if (exp_q[0]) begin
                    res_d = prod_lo;
                    if (prod_hi_nz) ovf_int_d = 1'b1;
                end
                state_d = S_SQR;
            end
            S_SQR: begin
                base_d = prod_lo;
                exp_d  = exp_shr;
                cnt_d  = cnt_q + CW'(1);
                // A square only matters if a later MUL will consume it.
                if (prod_hi_nz && (exp_shr != '0)) ovf_int_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Load results on entry so they are visible in DONE.
                    out_d   = res_q;
                    ovf_d   = ovf_int_d;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign OUT  = out_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_MUL) || (state_q == S_SQR);
    assign done = (state_q == S_DONE);

endmodule

// File: doc/pow_seq_ctrl.md
Name: pow_seq_ctrl

Overview:
- Sequential exponentiation controller: computes OUT = A^E mod 2^W using one shared W x W multiplier, iterated by an FSM.
- Algorithm is right-to-left square-and-multiply, giving a fixed latency that does not depend on the data.
- Extends the combinational power datapath to general exponents, with start/busy/done handshake and an overflow flag.
- Sits between a host/stimulus register bank and downstream result consumers.

Parameters:
- W, 7, data width of A, OUT and all internal result/base registers.
- EW, 3, exponent width; the iteration count equals EW.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  W  base; captured on the accepted start edge.
- E  input  EW  exponent; captured on the accepted start edge.
- OUT  output  W  registered result, A^E mod 2^W.
- busy  output  1  high while iterating (MUL/SQR states).
- done  output  1  one-cycle pulse; OUT and ovf are valid from that cycle.
- ovf  output  1  high when the true A^E is ≥ 2^W; valid with done.

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous):
  - State → IDLE.
  - OUT=0, busy=0, done=0, ovf=0; internal res/base/exp/cnt cleared.
  - Reset also aborts any in-flight operation; no done is produced for it.
- States: IDLE, MUL, SQR, DONE.
- Shared multiplier: one W x W → 2W product per cycle. Low W bits are kept. The high W bits are used only for overflow detection.
- IDLE:
  - On an edge with start=1: res←1, base←A, exp←E, cnt←0, ovf_int←0, state→MUL.
  - Otherwise stay in IDLE.
- MUL (busy=1):
  - If exp[0]=1: res←low(res*base); ovf_int set if high(res*base)≠0.
  - If exp[0]=0: res unchanged.
  - state→SQR.
- SQR (busy=1):
  - base←low(base*base); exp←exp>>1; cnt←cnt+1.
  - ovf_int set if high(base*base)≠0 AND (exp>>1)≠0. Overflow of a square that is never used must not flag.
  - If cnt=EW-1: state→DONE. Else state→MUL.
- DONE:
  - OUT←res and ovf←ovf_int (registered, visible in this cycle).
  - done=1 for exactly one cycle; busy=0; state→IDLE.
- Latency:
  - Start sampled at edge k.
  - MUL/SQR occupy cycles k+1 … k+2·EW.
  - done=1 in the cycle after edge k+2·EW+1. For EW=3 that is 7 edges after start.
  - Fixed for all A and E.
- OUT and ovf hold their values until the next DONE or reset. They do not change while busy.
- Handshake and boundaries:
  - start during MUL, SQR or DONE is ignored, with no queuing. The earliest new start is accepted in the IDLE cycle after done.
  - start held high continuously: back-to-back operations, one every 2·EW+2 cycles.
  - A and E changing while busy has no effect (they are captured at start).
  - E=0 → OUT=1, ovf=0 for any A, including A=0.
  - A=0, E>0 → OUT=0, ovf=0.
  - A=1 → OUT=1, ovf=0.
  - Result exactly 2^W → OUT=0, ovf=1 (wrap-around modulo 2^W).
  - Reset asserted in the same cycle as start: reset wins.

Test Plan:
1. Reset release, then A=3, E=4, start pulse → busy=1 for 6 cycles; done pulse 7 edges after start; OUT=1010001 (81), ovf=0.
2. A=5, E=3 → OUT=1111101 (125), ovf=0. Then A=2, E=7 → OUT=0000000, ovf=1 (128 wraps).
3. A=11, E=2 → OUT=1111001 (121), ovf=0. This checks that overflow of the unused 121² square does not set ovf.
4. Boundary checks:
   - A=0, E=0 → OUT=1, ovf=0.
   - A=127, E=1 → OUT=127, ovf=0.
   - A=127, E=2 → OUT=1, ovf=1.
5. Handshake:
   - start=1, A=3, E=2.
   - Pulse start again 2 cycles later with A=2, E=5.
   - Result: second start ignored; a single done with OUT=9.
   - start held high afterwards → the next op completes in exactly 8 cycles.
6. Reset mid-operation:
   - Start A=3, E=4; drive rst_n=0 on the 3rd busy cycle.
   - Result: next edge gives busy=0, OUT=0, ovf=0, no done pulse.
   - After rst_n=1, a new start computes correctly.
